// File: rtl/gpio_input_capture.sv
// GPIO input capture: per-bit synchronizer, debouncer, edge detect, sticky W1C status/overrun, level irq.
// Pin-to-gpio_value latency SYNC_STAGES+DEBOUNCE_CYCLES cycles; no backpressure, events latch until cleared.
module gpio_input_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_io_i,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] gpio_value,
  output logic [WIDTH-1:0] status,
  output logic [WIDTH-1:0] overrun,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][CW-1:0]          r_cnt;
  logic [WIDTH-1:0]                  r_value;
  logic [WIDTH-1:0]                  r_status;
  logic [WIDTH-1:0]                  r_overrun;
  logic                              r_irq;

  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0][CW-1:0]          w_cnt_next;
  logic [WIDTH-1:0]                  w_toggle;
  logic [WIDTH-1:0]                  w_event;
  logic [WIDTH-1:0]                  w_clr;
  logic [WIDTH-1:0]                  w_status_next;
  logic [WIDTH-1:0]                  w_overrun_next;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The counter only runs while the synchronized bit disagrees with the
  // debounced value; reaching the last count flips the value and rearms.
  always_comb begin
    w_toggle   = '0;
    w_cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_sync[i] != r_value[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_toggle[i] = 1'b1;
        end else begin
          w_cnt_next[i] = r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Direction comes from the current debounced value: 0 about to toggle is a rise.
  assign w_event        = w_toggle & ((~r_value & rise_en) | (r_value & fall_en));
  assign w_clr          = {WIDTH{clr_valid}} & clr_mask;
  assign w_status_next  = (r_status & ~w_clr) | w_event;
  assign w_overrun_next = (r_overrun & ~w_clr) | (w_event & r_status & ~w_clr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_value   <= '0;
      r_status  <= '0;
      r_overrun <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], gpio_io_i};
      r_cnt     <= w_cnt_next;
      r_value   <= r_value ^ w_toggle;
      r_status  <= w_status_next;
      r_overrun <= w_overrun_next;
      r_irq     <= |w_status_next;
    end
  end

  assign gpio_value = r_value;
  assign status     = r_status;
  assign overrun    = r_overrun;
  assign irq        = r_irq;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Scenario bench for gpio_input_capture (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected output snapshots are queued with their due cycle and checked on the falling edge.
module tb_gpio_input_capture;

  logic       clk;
  logic       resetn;
  logic [7:0] gpio_io_i;
  logic [7:0] rise_en;
  logic [7:0] fall_en;
  logic       clr_valid;
  logic [7:0] clr_mask;
  logic [7:0] gpio_value;
  logic [7:0] status;
  logic [7:0] overrun;
  logic       irq;

  gpio_input_capture #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .gpio_io_i(gpio_io_i),
    .rise_en(rise_en),
    .fall_en(fall_en),
    .clr_valid(clr_valid),
    .clr_mask(clr_mask),
    .gpio_value(gpio_value),
    .status(status),
    .overrun(overrun),
    .irq(irq)
  );

  typedef struct {
    int          cyc;
    string       tag;
    logic [24:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [24:0] obs;

  assign obs = {gpio_value, status, overrun, irq};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [24:0] pk(input logic [7:0] v, input logic [7:0] s,
                                     input logic [7:0] o, input logic i);
    return {v, s, o, i};
  endfunction

  task automatic push(input int c, input string t, input logic [24:0] e);
    sb_t x;
    x.cyc = c;
    x.tag = t;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic do_reset(input logic [7:0] pins);
    @(negedge clk);
    resetn    = 1'b0;
    gpio_io_i = pins;
    clr_valid = 1'b0;
    clr_mask  = 8'h00;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    sb_t e;
    int  n0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (obs !== e.exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
        end
      end
      if (k == 0) begin
        for (int d = 1; d <= 2; d++) push(n0 + d, "reset_hold", '0);
      end
      if (k == 2) begin
        resetn    = 1'b1;
        gpio_io_i = 8'h00;
        for (int d = 3; d <= 7; d++) push(n0 + d, "reset_release", '0);
      end
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL reset_drain: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_rise;
    sb_t e;
    int  n0;
    rise_en = 8'hFF;
    fall_en = 8'h00;
    do_reset(8'h00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (obs !== e.exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
        end
      end
      if (k == 0) begin
        gpio_io_i = 8'h01;
        for (int d = 1; d <= 5; d++) push(n0 + d, "rise_latency", '0);
        push(n0 + 6, "rise_seen", pk(8'h01, 8'h01, 8'h00, 1'b1));
        push(n0 + 8, "rise_hold", pk(8'h01, 8'h01, 8'h00, 1'b1));
      end
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL rise_drain: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_glitch;
    sb_t e;
    int  n0;
    rise_en = 8'hFF;
    fall_en = 8'h00;
    do_reset(8'h00);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (obs !== e.exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
        end
      end
      case (k)
        0: begin
          gpio_io_i = 8'h08;
          for (int d = 1; d <= 12; d++) push(n0 + d, "glitch_3cyc", '0);
        end
        3:  gpio_io_i = 8'h00;
        12: begin
          gpio_io_i = 8'h08;
          for (int d = 13; d <= 17; d++) push(n0 + d, "pulse4_pre", '0);
          for (int d = 18; d <= 21; d++) push(n0 + d, "pulse4_high", pk(8'h08, 8'h08, 8'h00, 1'b1));
          for (int d = 22; d <= 24; d++) push(n0 + d, "pulse4_low", pk(8'h00, 8'h08, 8'h00, 1'b1));
        end
        16: gpio_io_i = 8'h00;
        default: ;
      endcase
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL glitch_drain: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_edge_select;
    sb_t e;
    int  n0;
    rise_en = 8'h00;
    fall_en = 8'h20;
    do_reset(8'h00);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (obs !== e.exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
        end
      end
      if (k == 0) begin
        gpio_io_i = 8'h20;
        for (int d = 1; d <= 5; d++) push(n0 + d, "sel_pre", '0);
        for (int d = 6; d <= 15; d++) push(n0 + d, "sel_rise_masked", pk(8'h20, 8'h00, 8'h00, 1'b0));
      end
      if (k == 10) begin
        gpio_io_i = 8'h00;
        for (int d = 16; d <= 18; d++) push(n0 + d, "sel_fall", pk(8'h00, 8'h20, 8'h00, 1'b1));
      end
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL sel_drain: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_clear_overrun;
    sb_t e;
    int  n0;
    rise_en = 8'h01;
    fall_en = 8'h01;
    do_reset(8'h00);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (obs !== e.exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
        end
      end
      case (k)
        0: begin
          gpio_io_i = 8'h01;
          push(n0 + 6, "clr_setup", pk(8'h01, 8'h01, 8'h00, 1'b1));
          push(n0 + 7, "clr_setup_hold", pk(8'h01, 8'h01, 8'h00, 1'b1));
        end
        7: begin
          clr_valid = 1'b1; clr_mask = 8'h01;
          push(n0 + 8, "clr_plain", pk(8'h01, 8'h00, 8'h00, 1'b0));
          push(n0 + 13, "clr_plain_hold", pk(8'h01, 8'h00, 8'h00, 1'b0));
        end
        8: begin
          clr_valid = 1'b0; clr_mask = 8'h00; gpio_io_i = 8'h00;
        end
        13: begin
          clr_valid = 1'b1; clr_mask = 8'h01;
          push(n0 + 14, "clr_collide_empty", pk(8'h00, 8'h01, 8'h00, 1'b1));
        end
        14: begin
          clr_valid = 1'b0; clr_mask = 8'h00; gpio_io_i = 8'h01;
          push(n0 + 17, "mask_no_valid", pk(8'h00, 8'h01, 8'h00, 1'b1));
          push(n0 + 19, "mask_no_valid2", pk(8'h00, 8'h01, 8'h00, 1'b1));
          push(n0 + 20, "overrun_set", pk(8'h01, 8'h01, 8'h01, 1'b1));
        end
        16: clr_mask = 8'h01;
        20: begin
          clr_mask = 8'h00; gpio_io_i = 8'h00;
          push(n0 + 25, "overrun_hold", pk(8'h01, 8'h01, 8'h01, 1'b1));
        end
        25: begin
          clr_valid = 1'b1; clr_mask = 8'h01;
          push(n0 + 26, "clr_collide_set", pk(8'h00, 8'h01, 8'h00, 1'b1));
        end
        26: begin
          clr_valid = 1'b0; clr_mask = 8'h00;
        end
        27: begin
          clr_valid = 1'b1; clr_mask = 8'h01;
          push(n0 + 28, "clr_final", '0);
          push(n0 + 30, "clr_final_hold", '0);
        end
        28: begin
          clr_valid = 1'b0; clr_mask = 8'h00;
        end
        default: ;
      endcase
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL clr_drain: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset_mid_count;
    sb_t e;
    int  n0;
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    do_reset(8'h00);
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (obs !== e.exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
        end
      end
      case (k)
        0: begin
          gpio_io_i = 8'h02;
          push(n0 + 5, "midrst_pre", '0);
          push(n0 + 6, "midrst_bit1", pk(8'h02, 8'h02, 8'h00, 1'b1));
          push(n0 + 11, "midrst_counting", pk(8'h02, 8'h02, 8'h00, 1'b1));
        end
        7: gpio_io_i = 8'h06;
        11: begin
          gpio_io_i = 8'h00;
          #2 resetn = 1'b0;
          #1;
          push(cyc, "midrst_async", '0);
          while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_cmp++;
            if (obs !== e.exp) begin
              n_mis++;
              $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
            end
          end
        end
        12: begin
          resetn = 1'b1;
          for (int d = 13; d <= 26; d++) push(n0 + d, "midrst_quiet", '0);
        end
        default: ;
      endcase
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL midrst_drain: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_high_through_reset;
    sb_t e;
    int  n0;
    rise_en = 8'h0F;
    fall_en = 8'h00;
    do_reset(8'hFF);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (obs !== e.exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d: got %h required %h", e.tag, cyc, obs, e.exp);
        end
      end
      if (k == 0) begin
        for (int d = 1; d <= 4; d++) push(n0 + d, "hirst_pre", '0);
        for (int d = 5; d <= 8; d++) push(n0 + d, "hirst_rise", pk(8'hFF, 8'h0F, 8'h00, 1'b1));
      end
    end
    if (sbq.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL hirst_drain: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    resetn    = 1'b0;
    gpio_io_i = 8'hAA;
    rise_en   = 8'hFF;
    fall_en   = 8'hFF;
    clr_valid = 1'b0;
    clr_mask  = 8'h00;
    test_reset();
    test_rise();
    test_glitch();
    test_edge_select();
    test_clear_overrun();
    test_reset_mid_count();
    test_high_through_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gpio_input_capture.md
Name: gpio_input_capture

Overview:
- Input-side counterpart to the 8-bit GPIO output path.
- Samples external GPIO input pins into the fabric clock domain with a configurable synchronizer, then debounces each bit.
- Detects rising and falling edges on the debounced value and latches enabled edges into sticky status bits, overrun bits and a level interrupt.
- Status and overrun are cleared by a single-cycle write-1-to-clear strobe from the register/control logic.

Parameters:
- WIDTH, 8: number of GPIO input bits.
- SYNC_STAGES, 2: synchronizer flops per bit; legal range 2..4.
- DEBOUNCE_CYCLES, 3000: consecutive cycles a synchronized bit must differ from the debounced value before the debounced value changes (10 us at 300 MHz); legal minimum 1.

Ports:
- clk, input, 1: fabric clock; all logic in this single domain.
- resetn, input, 1: asynchronous assert, active-low reset.
- gpio_io_i, input, WIDTH: raw asynchronous pin inputs.
- rise_en, input, WIDTH: per-bit rising-edge event enable.
- fall_en, input, WIDTH: per-bit falling-edge event enable.
- clr_valid, input, 1: one-cycle clear strobe.
- clr_mask, input, WIDTH: bits to clear when clr_valid=1.
- gpio_value, output, WIDTH: debounced input value (registered).
- status, output, WIDTH: sticky edge-event flags (registered).
- overrun, output, WIDTH: an event arrived while the status bit was already set (registered).
- irq, output, 1: level interrupt, equals OR of status (registered).

Behaviour:
- Reset:
  - Clock is clk; reset is resetn, asynchronous, active-low.
  - While resetn=0: synchronizer flops, debounce counters, gpio_value, status, overrun and irq are all 0.
  - Deassertion takes effect at the next clk edge.
- Synchronizer:
  - SYNC_STAGES flop chain per bit; sync[i] is the last stage.
  - No combinational path from gpio_io_i to any output.
- Debounce (per bit, independent):
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync[i] == gpio_value[i]: the counter loads 0.
  - Otherwise: the counter increments. On the cycle the counter equals DEBOUNCE_CYCLES-1 with the mismatch still present, the next edge toggles gpio_value[i] and loads the counter with 0.
  - Any single matching sample during counting restarts the count from 0, so glitches shorter than DEBOUNCE_CYCLES never propagate.
  - Latency from a clean pin change to gpio_value: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - With DEBOUNCE_CYCLES=1, the value follows sync[i] one cycle later.
- Edge detect:
  - toggle[i] is asserted in the cycle gpio_value[i] is about to change.
  - event[i] = toggle[i] & ((rising & rise_en[i]) | (falling & fall_en[i])).
  - Enables are sampled in the toggle cycle only. Enabling later does not retroactively create an event.
- Status and overrun:
  - clr[i] = clr_valid & clr_mask[i].
  - status_next = (status & ~clr) | event. An event wins over a same-cycle clear.
  - overrun_next = (overrun & ~clr) | (event & status & ~clr).
  - A clear coincident with a new event leaves status=1 and does not set overrun.
  - clr_mask bits with clr_valid=0 are ignored.
- irq:
  - Registered as |status_next, so irq rises in the same cycle status is set.
  - irq falls in the cycle after the clear edge that zeroes the last status bit.
- Reset mid-operation:
  - All debounce counts are abandoned and outputs return to 0.
  - A pin held at 1 through reset produces a normal rising toggle SYNC_STAGES+DEBOUNCE_CYCLES cycles after release. It sets status if rise_en is set.
- Bits never interact; simultaneous events on several bits all latch in the same cycle.

Test Plan:
All scenarios use WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Basic rising edge: rise_en=0xFF, fall_en=0x00; gpio_io_i 0x00→0x01 at edge N -> gpio_value=0x01, status=0x01 and irq=1 all first visible after edge N+6; overrun=0x00.
2. Glitch rejection: bit3 pulses high for 3 cycles, then low -> gpio_value, status and irq stay 0x00/0x00/0. A 4-cycle pulse -> gpio_value[3] goes to 1 for 4 cycles, then back to 0.
3. Edge selection: rise_en=0x00, fall_en=0x20; bit5 goes 0→1, held for 10 cycles, then 1→0 -> status stays 0x00 after the rise; status=0x20 and irq=1 appear 6 cycles after the fall.
4. Clear, collision and overrun:
   - With status=0x01, pulse clr_valid with clr_mask=0x01 -> status=0x00 and irq=0 next cycle.
   - Repeat with the clear coincident with a new bit0 event -> status=0x01, overrun=0x00.
   - A further bit0 event with no clear -> overrun=0x01.
   - clr_mask=0x01 -> status=0x00, overrun=0x00.
5. Reset mid-count: bit2 differs for 2 debounce cycles, then resetn=0 asynchronously between edges -> all outputs 0 immediately; after release with pin now 0, no event ever occurs.
6. Pin high through reset: gpio_io_i=0xFF during reset, rise_en=0x0F -> 6 cycles after release gpio_value=0xFF, status=0x0F, irq=1.
